// File: rtl/tcam_entry_writer_pkg.sv
// ---------------------------------------------------------------------------
// tcam_wr_pkg
// Shared constants for the TCAM entry writer: geometry, command op codes,
// response status codes, FSM state encodings and key helpers.
// Optional feature macro used by the writer: TCAM_READBACK_EN.
// ---------------------------------------------------------------------------
package tcam_wr_pkg;

  localparam int KEY_W  = 4;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // command op codes
  localparam logic [1:0] OP_READ       = 2'b00;
  localparam logic [1:0] OP_WRITE      = 2'b01;
  localparam logic [1:0] OP_INVALIDATE = 2'b10;
  localparam logic [1:0] OP_CLEAR_ALL  = 2'b11;

  // response status codes
  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_KEY_NORM = 2'b01;
  localparam logic [1:0] ST_UNSUP    = 2'b11;

  // FSM state encodings
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_WRITE = 2'd1;
  localparam state_t S_SWEEP = 2'd2;
  localparam state_t S_RESP  = 2'd3;

  // Stored key: don't-care bits are forced to zero.
  function automatic logic [KEY_W-1:0] norm_key(input logic [KEY_W-1:0] key,
                                                input logic [KEY_W-1:0] mask);
    return key & mask;
  endfunction

  // True when the key carries ones in bit positions the mask ignores.
  function automatic logic key_needs_norm(input logic [KEY_W-1:0] key,
                                          input logic [KEY_W-1:0] mask);
    return (key & ~mask) != {KEY_W{1'b0}};
  endfunction

endpackage

// File: rtl/tcam_entry_writer_if.sv
// ---------------------------------------------------------------------------
// tcam_entry_writer_if
// Bundles the command, response, TCAM write port, lookup stall and valid
// bitmap signals of the TCAM entry writer.
//   master : control-plane side (drives commands, lookup_busy, rsp_rdy)
//   slave  : the writer (drives cmd_rdy, wr_*, rsp_*, entry_valid)
// ---------------------------------------------------------------------------
interface tcam_entry_writer_if;
  import tcam_wr_pkg::*;

  logic              cmd_vld;
  logic              cmd_rdy;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [KEY_W-1:0]  cmd_key;
  logic [KEY_W-1:0]  cmd_mask;
  logic              lookup_busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [KEY_W-1:0]  wr_key;
  logic [KEY_W-1:0]  wr_mask;
  logic              wr_valid;
  logic              rsp_vld;
  logic              rsp_rdy;
  logic [1:0]        rsp_status;
  logic [KEY_W-1:0]  rsp_key;
  logic [KEY_W-1:0]  rsp_mask;
  logic [DEPTH-1:0]  entry_valid;

  modport master (
    output cmd_vld, cmd_op, cmd_addr, cmd_key, cmd_mask, lookup_busy, rsp_rdy,
    input  cmd_rdy, wr_en, wr_addr, wr_key, wr_mask, wr_valid,
           rsp_vld, rsp_status, rsp_key, rsp_mask, entry_valid
  );

  modport slave (
    input  cmd_vld, cmd_op, cmd_addr, cmd_key, cmd_mask, lookup_busy, rsp_rdy,
    output cmd_rdy, wr_en, wr_addr, wr_key, wr_mask, wr_valid,
           rsp_vld, rsp_status, rsp_key, rsp_mask, entry_valid
  );

endinterface

// File: rtl/tcam_entry_writer_shadow_regs.sv
// ---------------------------------------------------------------------------
// tcam_shadow_regs
// Shadow copy of every TCAM entry's {key, mask} so software can read entries
// back. One synchronous write port, asynchronous read. Only built when the
// TCAM_READBACK_EN macro is defined.
// Ports: clk, reset (async, active-high), we, waddr, wdata, raddr, rdata.
// ---------------------------------------------------------------------------
`ifdef TCAM_READBACK_EN
module tcam_shadow_regs
  import tcam_wr_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [2*KEY_W-1:0]   wdata,
  input  logic [ADDR_W-1:0]    raddr,
  output logic [2*KEY_W-1:0]   rdata
);

  logic [2*KEY_W-1:0] mem_r [DEPTH];

  // Shadow storage, written alongside the TCAM write strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {(2*KEY_W){1'b0}};
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule
`endif

// File: rtl/tcam_entry_writer.sv
// ---------------------------------------------------------------------------
// tcam_entry_writer
// Control-plane write side of the match TCAM. Accepts READ / WRITE /
// INVALIDATE / CLEAR_ALL commands, drives the TCAM entry write port one entry
// per cycle, stalls writes while a lookup is in flight and keeps a per-entry
// valid bitmap.
// Ports: clk, reset (async, active-high), bus (tcam_entry_writer_if.slave).
// Optional feature: TCAM_READBACK_EN adds a shadow key/mask store so READ
// returns entry contents; without it READ answers UNSUPPORTED.
// ---------------------------------------------------------------------------
module tcam_entry_writer
  import tcam_wr_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  tcam_entry_writer_if.slave bus
);

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] addr_r;
  logic [KEY_W-1:0]  key_r, mask_r;
  logic              valid_r;
  logic [1:0]        status_r;
  logic [KEY_W-1:0]  rsp_key_r, rsp_mask_r;
  logic [DEPTH-1:0]  entry_valid_r;
  logic              accept_s;
  logic              wr_fire_s;
  logic [1:0]        rd_status_s;
  logic [KEY_W-1:0]  rd_key_s, rd_mask_s;

  assign accept_s  = bus.cmd_vld && bus.cmd_rdy;
  // The lookup stall gates the strobe combinationally so no write ever
  // overlaps a busy cycle; the sweep address simply holds meanwhile.
  assign wr_fire_s = ((state_r == S_WRITE) || (state_r == S_SWEEP)) && !bus.lookup_busy;

`ifdef TCAM_READBACK_EN
  logic [2*KEY_W-1:0] shadow_rd_s;

  tcam_shadow_regs u_shadow (
    .clk   (clk),
    .reset (reset),
    .we    (wr_fire_s),
    .waddr (addr_r),
    .wdata ({key_r, mask_r}),
    .raddr (bus.cmd_addr),
    .rdata (shadow_rd_s)
  );

  // READ answer from the shadow store; an invalid entry is flagged with 01.
  always_comb begin
    rd_key_s  = shadow_rd_s[2*KEY_W-1:KEY_W];
    rd_mask_s = shadow_rd_s[KEY_W-1:0];
    if (entry_valid_r[bus.cmd_addr]) begin
      rd_status_s = ST_OK;
    end else begin
      rd_status_s = ST_KEY_NORM;
    end
  end
`else
  assign rd_status_s = ST_UNSUP;
  assign rd_key_s    = {KEY_W{1'b0}};
  assign rd_mask_s   = {KEY_W{1'b0}};
`endif

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          case (bus.cmd_op)
            OP_WRITE, OP_INVALIDATE: state_s = S_WRITE;
            OP_CLEAR_ALL:            state_s = S_SWEEP;
            OP_READ:                 state_s = S_RESP;
            default:                 state_s = S_IDLE;
          endcase
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WRITE: begin
        if (wr_fire_s) state_s = S_RESP;
        else           state_s = S_WRITE;
      end
      S_SWEEP: begin
        if (wr_fire_s && (addr_r == LAST_ADDR)) state_s = S_RESP;
        else                                    state_s = S_SWEEP;
      end
      S_RESP: begin
        if (bus.rsp_rdy) state_s = S_IDLE;
        else             state_s = S_RESP;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= S_IDLE;
    else       state_r <= state_s;
  end

  // Command capture at accept, plus the sweep address counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r     <= {ADDR_W{1'b0}};
      key_r      <= {KEY_W{1'b0}};
      mask_r     <= {KEY_W{1'b0}};
      valid_r    <= 1'b0;
      status_r   <= ST_OK;
      rsp_key_r  <= {KEY_W{1'b0}};
      rsp_mask_r <= {KEY_W{1'b0}};
    end else if (accept_s) begin
      rsp_key_r  <= {KEY_W{1'b0}};
      rsp_mask_r <= {KEY_W{1'b0}};
      case (bus.cmd_op)
        OP_WRITE: begin
          addr_r   <= bus.cmd_addr;
          key_r    <= norm_key(bus.cmd_key, bus.cmd_mask);
          mask_r   <= bus.cmd_mask;
          valid_r  <= 1'b1;
          status_r <= key_needs_norm(bus.cmd_key, bus.cmd_mask) ? ST_KEY_NORM : ST_OK;
        end
        OP_INVALIDATE: begin
          addr_r   <= bus.cmd_addr;
          key_r    <= {KEY_W{1'b0}};
          mask_r   <= {KEY_W{1'b0}};
          valid_r  <= 1'b0;
          status_r <= ST_OK;
        end
        OP_CLEAR_ALL: begin
          addr_r   <= {ADDR_W{1'b0}};
          key_r    <= {KEY_W{1'b0}};
          mask_r   <= {KEY_W{1'b0}};
          valid_r  <= 1'b0;
          status_r <= ST_OK;
        end
        default: begin
          status_r   <= rd_status_s;
          rsp_key_r  <= rd_key_s;
          rsp_mask_r <= rd_mask_s;
        end
      endcase
    end else if ((state_r == S_SWEEP) && wr_fire_s && (addr_r != LAST_ADDR)) begin
      addr_r <= addr_r + ADDR_W'(1);
    end
  end

  // Valid bitmap follows every write strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          entry_valid_r <= {DEPTH{1'b0}};
    else if (wr_fire_s) entry_valid_r[addr_r] <= valid_r;
  end

  // cmd_rdy is held low while reset is asserted.
  assign bus.cmd_rdy     = (state_r == S_IDLE) && !reset;
  assign bus.wr_en       = wr_fire_s;
  assign bus.wr_addr     = addr_r;
  assign bus.wr_key      = key_r;
  assign bus.wr_mask     = mask_r;
  assign bus.wr_valid    = valid_r;
  assign bus.rsp_vld     = (state_r == S_RESP);
  assign bus.rsp_status  = status_r;
  assign bus.rsp_key     = rsp_key_r;
  assign bus.rsp_mask    = rsp_mask_r;
  assign bus.entry_valid = entry_valid_r;

endmodule

// File: tb/tb_tcam_entry_writer.sv
// ---------------------------------------------------------------------------
// tb_tcam_entry_writer
// Directed self-checking bench for tcam_entry_writer. Expected TCAM writes
// and responses are queued when each command is issued and popped by a
// monitor when the DUT produces them. Honours TCAM_READBACK_EN.
// ---------------------------------------------------------------------------
module tb_tcam_entry_writer;
  import tcam_wr_pkg::*;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [KEY_W-1:0]  key;
    logic [KEY_W-1:0]  mask;
    logic              valid;
  } wr_t;

  typedef struct packed {
    logic [1:0]       status;
    logic [KEY_W-1:0] key;
    logic [KEY_W-1:0] mask;
  } rsp_t;

  logic clk;
  logic reset;
  tcam_entry_writer_if bus();

  tcam_entry_writer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  wr_t  wr_q[$];
  rsp_t rsp_q[$];
  wr_t  mon_wr_exp;
  rsp_t mon_rsp_exp;
  int   total = 0;
  int   bad   = 0;
  int   wr_cnt = 0;
  int   base;
  int   g;
  logic [DEPTH-1:0] m_valid;
  logic [KEY_W-1:0] m_key  [DEPTH];
  logic [KEY_W-1:0] m_mask [DEPTH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    m_valid = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      m_key[i]  = {KEY_W{1'b0}};
      m_mask[i] = {KEY_W{1'b0}};
    end
  endtask

  // Queue the expected effects, then present the command until accepted.
  task automatic issue(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                       input logic [KEY_W-1:0] key, input logic [KEY_W-1:0] mask);
    int w;
    w = 0;
    while (bus.cmd_rdy !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    chk("cmd_rdy_wait", 32'(w < 50), 32'd1);
    case (op)
      OP_WRITE: begin
        wr_q.push_back(wr_t'({addr, key & mask, mask, 1'b1}));
        rsp_q.push_back(rsp_t'({(((key & ~mask) != 4'b0000) ? ST_KEY_NORM : ST_OK),
                                4'b0000, 4'b0000}));
        m_valid[addr] = 1'b1;
        m_key[addr]   = key & mask;
        m_mask[addr]  = mask;
      end
      OP_INVALIDATE: begin
        wr_q.push_back(wr_t'({addr, 4'b0000, 4'b0000, 1'b0}));
        rsp_q.push_back(rsp_t'({ST_OK, 4'b0000, 4'b0000}));
        m_valid[addr] = 1'b0;
        m_key[addr]   = 4'b0000;
        m_mask[addr]  = 4'b0000;
      end
      OP_CLEAR_ALL: begin
        for (int i = 0; i < DEPTH; i++) begin
          wr_q.push_back(wr_t'({ADDR_W'(i), 4'b0000, 4'b0000, 1'b0}));
        end
        rsp_q.push_back(rsp_t'({ST_OK, 4'b0000, 4'b0000}));
        clear_model();
      end
      default: begin
`ifdef TCAM_READBACK_EN
        rsp_q.push_back(rsp_t'({(m_valid[addr] ? ST_OK : ST_KEY_NORM), m_key[addr], m_mask[addr]}));
`else
        rsp_q.push_back(rsp_t'({ST_UNSUP, 4'b0000, 4'b0000}));
`endif
      end
    endcase
    bus.cmd_vld  = 1'b1;
    bus.cmd_op   = op;
    bus.cmd_addr = addr;
    bus.cmd_key  = key;
    bus.cmd_mask = mask;
    tick();
    bus.cmd_vld  = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int w;
    w = 0;
    while (bus.rsp_vld !== 1'b1 && w < 60) begin
      tick();
      w++;
    end
    chk(tag, 32'(w < 60), 32'd1);
  endtask

  // Scoreboard monitor: compares every write strobe and completed response.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus.wr_en === 1'b1) begin
        wr_cnt++;
        chk("wr_while_busy", 32'(bus.lookup_busy), 32'd0);
        chk("wr_expected", 32'(wr_q.size() > 0), 32'd1);
        if (wr_q.size() > 0) begin
          mon_wr_exp = wr_q.pop_front();
          chk("wr_port", 32'({bus.wr_addr, bus.wr_key, bus.wr_mask, bus.wr_valid}),
              32'(mon_wr_exp));
        end
      end
      if (bus.rsp_vld === 1'b1 && bus.rsp_rdy === 1'b1) begin
        chk("rsp_expected", 32'(rsp_q.size() > 0), 32'd1);
        if (rsp_q.size() > 0) begin
          mon_rsp_exp = rsp_q.pop_front();
          chk("rsp_fields", 32'({bus.rsp_status, bus.rsp_key, bus.rsp_mask}),
              32'(mon_rsp_exp));
        end
      end
    end
  end

  initial begin
    reset           = 1'b1;
    bus.cmd_vld     = 1'b0;
    bus.cmd_op      = 2'b00;
    bus.cmd_addr    = 4'd0;
    bus.cmd_key     = 4'd0;
    bus.cmd_mask    = 4'd0;
    bus.lookup_busy = 1'b0;
    bus.rsp_rdy     = 1'b1;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_rsp_vld", 32'(bus.rsp_vld), 32'd0);
    chk("rst_entry_valid", 32'(bus.entry_valid), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
    chk("rst_rsp_status", 32'(bus.rsp_status), 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);

    // WRITE, key fully inside the mask
    issue(OP_WRITE, 4'd3, 4'b1010, 4'b1110);
    chk("w3_wr_en_t1", 32'(bus.wr_en), 32'd1);
    chk("w3_wr_key", 32'(bus.wr_key), 32'b1010);
    tick();
    chk("w3_rsp_vld_t2", 32'(bus.rsp_vld), 32'd1);
    chk("w3_entry_valid", 32'(bus.entry_valid[3]), 32'd1);
    chk("w3_status", 32'(bus.rsp_status), 32'd0);
    tick();
    chk("w3_cmd_rdy_after", 32'(bus.cmd_rdy), 32'd1);

    // WRITE needing key normalisation
    issue(OP_WRITE, 4'd5, 4'b1011, 4'b0110);
    chk("w5_wr_key", 32'(bus.wr_key), 32'b0010);
    tick();
    chk("w5_status", 32'(bus.rsp_status), 32'd1);

    // lookup_busy held for three cycles after accept
    bus.lookup_busy = 1'b1;
    base = wr_cnt;
    issue(OP_WRITE, 4'd8, 4'b0001, 4'b1111);
    chk("busy_c1", 32'(bus.wr_en), 32'd0);
    tick();
    chk("busy_c2", 32'(bus.wr_en), 32'd0);
    tick();
    chk("busy_c3", 32'(bus.wr_en), 32'd0);
    tick();
    bus.lookup_busy = 1'b0;
    #1;
    chk("busy_release_wr", 32'(bus.wr_en), 32'd1);
    tick();
    chk("busy_single_pulse", 32'(wr_cnt - base), 32'd1);
    chk("busy_rsp_vld", 32'(bus.rsp_vld), 32'd1);
    tick();
    chk("busy_no_extra", 32'(wr_cnt - base), 32'd1);

    // response back-pressure for five cycles
    bus.rsp_rdy = 1'b0;
    issue(OP_WRITE, 4'd6, 4'b1001, 4'b0001);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp_vld", 32'(bus.rsp_vld), 32'd1);
      chk("hold_status", 32'(bus.rsp_status), 32'd1);
      chk("hold_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
      if (i == 0) begin
        bus.cmd_vld = 1'b1;
        bus.cmd_op  = OP_INVALIDATE;
        bus.cmd_addr = 4'd3;
      end
      if (i < 4) tick();
    end
    bus.cmd_vld = 1'b0;
    bus.rsp_rdy = 1'b1;
    tick();
    chk("hold_cmd_rdy_after", 32'(bus.cmd_rdy), 32'd1);
    chk("hold_no_accept_ev3", 32'(bus.entry_valid[3]), 32'd1);

    // INVALIDATE
    issue(OP_INVALIDATE, 4'd5, 4'b1111, 4'b1111);
    wait_rsp("inv_rsp_wait");
    tick();
    chk("inv_ev5", 32'(bus.entry_valid[5]), 32'd0);
    chk("inv_ev3_kept", 32'(bus.entry_valid[3]), 32'd1);

    // CLEAR_ALL with a two-cycle stall at address 7
    base = wr_cnt;
    issue(OP_CLEAR_ALL, 4'd9, 4'd0, 4'd0);
    g = 0;
    while (bus.wr_addr !== 4'd7 && g < 30) begin
      tick();
      g++;
    end
    chk("clr_reach_7", 32'(g < 30), 32'd1);
    bus.lookup_busy = 1'b1;
    #1;
    chk("clr_stall_c1", 32'(bus.wr_en), 32'd0);
    tick();
    chk("clr_stall_c2", 32'(bus.wr_en), 32'd0);
    chk("clr_stall_addr", 32'(bus.wr_addr), 32'd7);
    tick();
    bus.lookup_busy = 1'b0;
    #1;
    chk("clr_resume_en", 32'(bus.wr_en), 32'd1);
    chk("clr_resume_addr", 32'(bus.wr_addr), 32'd7);
    wait_rsp("clr_rsp_wait");
    chk("clr_wr_count", 32'(wr_cnt - base), 32'd16);
    chk("clr_entry_valid", 32'(bus.entry_valid), 32'h0000);
    chk("clr_last_addr", 32'(bus.wr_addr), 32'd15);
    tick();

    // reset in the middle of a sweep
    issue(OP_WRITE, 4'd12, 4'b1111, 4'b1111);
    wait_rsp("w12_rsp_wait");
    tick();
    issue(OP_CLEAR_ALL, 4'd0, 4'd0, 4'd0);
    g = 0;
    while (bus.wr_addr !== 4'd9 && g < 30) begin
      tick();
      g++;
    end
    chk("rst9_reach", 32'(g < 30), 32'd1);
    chk("rst9_pre_ev12", 32'(bus.entry_valid[12]), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst9_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst9_rsp_vld", 32'(bus.rsp_vld), 32'd0);
    chk("rst9_entry_valid", 32'(bus.entry_valid), 32'h0000);
    wr_q.delete();
    rsp_q.delete();
    clear_model();
    tick();
    reset = 1'b0;
    #1;
    chk("rst9_cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
    chk("rst9_wr_en_after", 32'(bus.wr_en), 32'd0);

    // READ back a written entry and an unwritten one
    issue(OP_WRITE, 4'd3, 4'b1100, 4'b1100);
    wait_rsp("w3b_rsp_wait");
    tick();
    base = wr_cnt;
    issue(OP_READ, 4'd3, 4'd0, 4'd0);
    chk("rd3_rsp_vld_t1", 32'(bus.rsp_vld), 32'd1);
    tick();
    chk("rd3_no_write", 32'(wr_cnt - base), 32'd0);
    issue(OP_READ, 4'd4, 4'd0, 4'd0);
    chk("rd4_rsp_vld_t1", 32'(bus.rsp_vld), 32'd1);
    tick();
    tick();

    chk("drain_wr_q", 32'(wr_q.size()), 32'd0);
    chk("drain_rsp_q", 32'(rsp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
